steer_sched: RTL and testbench
==============================

STEER_SCHED -- requirements
Module: steer_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000000, meaning the maximum number of WAIT cycles allowed per channel move.
REQ-002 SHALL have parameter TMR_W, default 26, meaning the timeout counter width; TIMEOUT_CYCLES SHALL fit in TMR_W bits.
REQ-003 SHALL have port clock  input  1  the main clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  host write strobe, sampled each cycle.
REQ-006 SHALL have port wr_ch  input  2  target channel for the write.
REQ-007 SHALL have port wr_angle  input  12  requested steering angle in degrees (0-359).
REQ-008 SHALL have port wr_err  output  1  one-cycle pulse for a rejected write.
REQ-009 SHALL have port target_angle  output  48  per-channel angle to the steering controllers; channel n at [12n+11:12n].
REQ-010 SHALL have port angle_update  output  4  one-hot, one-cycle move request, one bit per channel.
REQ-011 SHALL have port angle_done  input  4  per-channel "at target" indication from the steering controllers.
REQ-012 SHALL have port pending  output  4  channels holding an unserved angle.
REQ-013 SHALL have port timeout_flag  output  4  sticky per-channel move-timeout status.
REQ-014 SHALL have port busy  output  1  high when the FSM is not IDLE.
REQ-015 SHALL have port active_ch  output  2  channel currently being served.

Function
REQ-016 SHALL move only one steering channel at a time, because of the shared motor power budget.
REQ-017 SHALL treat a write as rejected when wr_angle > 359: wr_err SHALL pulse in the next cycle, and no shadow or pending state SHALL change.
REQ-018 SHALL handle an accepted write at cycle N as follows: shadow[wr_ch] <= wr_angle and pending[wr_ch] <= 1, both visible at N+1.
REQ-019 SHALL let a later write to an already-pending channel overwrite its shadow (last write wins), with a single pending bit.
REQ-020 SHALL implement the FSM states IDLE, ISSUE and WAIT.
REQ-021 SHALL, in IDLE with pending != 0, select the next pending channel round-robin, starting from last_served+1 and wrapping 3->0, and go to ISSUE.
REQ-022 SHALL, in IDLE with pending == 0, remain in IDLE.
REQ-023 SHALL, on entry to ISSUE, load target_angle[ch] from shadow[ch], set active_ch = ch and last_served = ch, and clear pending[ch].
REQ-024 SHALL keep pending[ch] set, rather than clearing it, if an accepted write to ch arrives in the same cycle as entry to ISSUE.
REQ-025 SHALL assert angle_update[ch] high for exactly the single ISSUE cycle; ISSUE SHALL then go to WAIT unconditionally.
REQ-026 SHALL hold target_angle for a channel stable except on that channel's ISSUE entry.
REQ-027 SHALL clear the timer on entry to WAIT and increment it each WAIT cycle.
REQ-028 SHALL ignore angle_done during the ISSUE cycle, since it may reflect the previous move.
REQ-029 SHALL, in WAIT with angle_done[active_ch] == 1, clear timeout_flag[active_ch] and go to IDLE.
REQ-030 SHALL, in WAIT with timer == TIMEOUT_CYCLES-1 and no done, set timeout_flag[active_ch] and go to IDLE.
REQ-031 SHALL give done priority when done and timeout occur in the same cycle.
REQ-032 SHALL ignore angle_done bits for non-active channels.
REQ-033 SHALL, for a write to active_ch during WAIT, update the shadow and set pending; the current move SHALL complete and the channel SHALL be re-served by round-robin.
REQ-034 SHALL give a write to an idle scheduler at cycle N an angle_update pulse at cycle N+2.
REQ-035 SHALL allow a minimum of 3 cycles between consecutive angle_update pulses.
REQ-036 SHALL drive busy = 1 in ISSUE and WAIT.

Reset
REQ-037 SHALL, while reset is high, hold the FSM in IDLE and clear pending, timeout_flag, shadows, target_angle, angle_update, wr_err, busy, active_ch and the timer to 0, and set last_served = 3 so that channel 0 has first priority.
REQ-038 SHALL, on reset asserted mid-move, drop angle_update low asynchronously and discard all pending requests.

Verification
REQ-039 SHALL cover a single move: write ch2=90 at N -> angle_update=4'b0100 at N+2, target_angle[35:24]=90; angle_done[2] at N+10 -> busy=0 at N+11, pending=0.
REQ-040 SHALL cover round-robin: writes ch0=10, ch1=20, ch3=30 with done returned promptly -> angle_update sequence ch0, ch1, ch3, each target matching its write.
REQ-041 SHALL cover timeout with TIMEOUT_CYCLES=100: write ch1=45 and never assert done -> timeout_flag=4'b0010 exactly 100 WAIT cycles after ISSUE; a later successful ch1 move clears it.
REQ-042 SHALL cover a rejected write: wr_angle=360 -> one-cycle wr_err, pending unchanged, no angle_update.
REQ-043 SHALL cover a rewrite during WAIT: ch0=100 active, write ch0=200 -> target stays 100 until done, then a second ISSUE with target 200.
REQ-044 SHALL cover reset mid-WAIT: assert reset -> angle_update=0, pending=0, busy=0 immediately; after release, the first write to ch3 is served first.

Source files
------------

// File: rtl/steer_sched.sv
// Steering move scheduler: buffers per-channel angle writes and issues
// moves one channel at a time, round-robin, with per-move timeout.
module steer_sched #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TMR_W          = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_ch,
  input  logic [11:0] wr_angle,
  output logic        wr_err,
  output logic [47:0] target_angle,
  output logic [3:0]  angle_update,
  input  logic [3:0]  angle_done,
  output logic [3:0]  pending,
  output logic [3:0]  timeout_flag,
  output logic        busy,
  output logic [1:0]  active_ch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t state, state_n;

  logic [3:0][11:0] shadow;
  logic [3:0][11:0] tgt;
  logic [TMR_W-1:0] timer;
  logic [1:0]       last_served;
  logic [1:0]       sel;
  logic             found;
  logic             issue;
  logic             done_hit;
  logic             tmo_hit;
  logic             accept;
  logic [3:0]       pending_n;

  assign accept       = wr_en && (wr_angle <= 12'd359);
  assign target_angle = tgt;
  assign busy         = (state != IDLE);

  // Round-robin search starting just after the last served channel.
  always_comb begin : rr
    logic [1:0] idx;
    sel   = last_served;
    found = 1'b0;
    idx   = last_served;
    for (int i = 1; i <= 4; i++) begin
      idx = last_served + 2'(i);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    issue    = 1'b0;
    done_hit = 1'b0;
    tmo_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = ISSUE;
          issue   = 1'b1;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (angle_done[active_ch]) begin
          state_n  = IDLE;
          done_hit = 1'b1;
        end else if (timer == TMR_MAX) begin
          state_n = IDLE;
          tmo_hit = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Clear on issue first so a same-cycle write re-arms the channel.
  always_comb begin
    pending_n = pending;
    if (issue)  pending_n[sel]   = 1'b0;
    if (accept) pending_n[wr_ch] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow       <= '0;
      tgt          <= '0;
      pending      <= '0;
      timeout_flag <= '0;
      angle_update <= '0;
      wr_err       <= 1'b0;
      active_ch    <= 2'd0;
      last_served  <= 2'd3;
      timer        <= '0;
    end else begin
      wr_err       <= wr_en && !accept;
      pending      <= pending_n;
      angle_update <= issue ? (4'b0001 << sel) : 4'b0000;
      if (accept) shadow[wr_ch] <= wr_angle;
      if (issue) begin
        tgt[sel]    <= shadow[sel];
        active_ch   <= sel;
        last_served <= sel;
      end
      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + TMR_W'(1);
      if (done_hit) timeout_flag[active_ch] <= 1'b0;
      if (tmo_hit)  timeout_flag[active_ch] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_steer_sched.sv
// Directed bench for steer_sched with a short timeout.
module tb_steer_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = 2'd0;
  logic [11:0] wr_angle = 12'd0;
  logic        wr_err;
  logic [47:0] target_angle;
  logic [3:0]  angle_update;
  logic [3:0]  angle_done = 4'd0;
  logic [3:0]  pending;
  logic [3:0]  timeout_flag;
  logic        busy;
  logic [1:0]  active_ch;

  int checks = 0;
  int failures = 0;

  steer_sched #(
    .TIMEOUT_CYCLES(100),
    .TMR_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_angle(wr_angle),
    .wr_err(wr_err),
    .target_angle(target_angle),
    .angle_update(angle_update),
    .angle_done(angle_done),
    .pending(pending),
    .timeout_flag(timeout_flag),
    .busy(busy),
    .active_ch(active_ch)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs,
                     input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int ch, input int ang);
    wr_en    = 1'b1;
    wr_ch    = 2'(ch);
    wr_angle = 12'(ang);
  endtask

  function automatic logic [11:0] tgt_of(input int ch);
    return target_angle[12*ch +: 12];
  endfunction

  task automatic wait_update(input int ch, input int ang, input string tag);
    int n = 0;
    while (angle_update == 4'd0 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_upd"}, 48'(angle_update), 48'(4'b0001 << ch));
    chk({tag, "_tgt"}, 48'(tgt_of(ch)), 48'(ang));
  endtask

  task automatic finish_move(input int ch);
    step();
    angle_done = 4'(4'b0001 << ch);
    step();
    angle_done = 4'd0;
  endtask

  initial begin
    step();
    step();
    chk("rst_pend", 48'(pending), 48'd0);
    chk("rst_upd", 48'(angle_update), 48'd0);
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_tgt", target_angle, 48'd0);
    chk("rst_tmo", 48'(timeout_flag), 48'd0);
    chk("rst_err", 48'(wr_err), 48'd0);
    reset = 1'b0;
    step();

    // Single move on channel 2.
    put(2, 90);
    step();
    wr_en = 1'b0;
    chk("s_pend1", 48'(pending), 48'h4);
    chk("s_upd1", 48'(angle_update), 48'd0);
    step();
    chk("s_upd2", 48'(angle_update), 48'h4);
    chk("s_tgt", 48'(tgt_of(2)), 48'd90);
    chk("s_act", 48'(active_ch), 48'd2);
    chk("s_busy2", 48'(busy), 48'd1);
    chk("s_pend2", 48'(pending), 48'd0);
    step();
    chk("s_upd3", 48'(angle_update), 48'd0);
    angle_done = 4'b0001;
    step();
    chk("s_other_done", 48'(busy), 48'd1);
    angle_done = 4'd0;
    repeat (6) step();
    angle_done = 4'b0100;
    step();
    angle_done = 4'd0;
    chk("s_idle", 48'(busy), 48'd0);
    chk("s_pend3", 48'(pending), 48'd0);

    // Round-robin over channels 0, 1, 3.
    put(0, 10);
    step();
    put(1, 20);
    step();
    chk("rr0_upd", 48'(angle_update), 48'h1);
    chk("rr0_tgt", 48'(tgt_of(0)), 48'd10);
    put(3, 30);
    step();
    wr_en = 1'b0;
    angle_done = 4'b0001;
    step();
    angle_done = 4'd0;
    chk("rr_pend", 48'(pending), 48'hA);
    wait_update(1, 20, "rr1");
    finish_move(1);
    wait_update(3, 30, "rr3");
    finish_move(3);
    chk("rr_done", 48'(pending), 48'd0);

    // Timeout on channel 1, then a clean move clears it.
    put(1, 45);
    step();
    wr_en = 1'b0;
    wait_update(1, 45, "to");
    repeat (100) step();
    chk("to_pre", 48'(timeout_flag), 48'd0);
    chk("to_busy", 48'(busy), 48'd1);
    step();
    chk("to_flag", 48'(timeout_flag), 48'h2);
    chk("to_idle", 48'(busy), 48'd0);
    put(1, 50);
    step();
    wr_en = 1'b0;
    wait_update(1, 50, "to2");
    finish_move(1);
    chk("to_clr", 48'(timeout_flag), 48'd0);

    // Rejected write and the 359 boundary.
    put(0, 360);
    step();
    wr_en = 1'b0;
    chk("rej_err", 48'(wr_err), 48'd1);
    chk("rej_pend", 48'(pending), 48'd0);
    step();
    chk("rej_err2", 48'(wr_err), 48'd0);
    chk("rej_upd", 48'(angle_update), 48'd0);
    step();
    chk("rej_busy", 48'(busy), 48'd0);
    put(0, 359);
    step();
    wr_en = 1'b0;
    chk("b359_err", 48'(wr_err), 48'd0);
    wait_update(0, 359, "b359");
    finish_move(0);

    // Rewrite of the active channel during WAIT.
    put(0, 100);
    step();
    wr_en = 1'b0;
    wait_update(0, 100, "rw1");
    step();
    put(0, 200);
    step();
    wr_en = 1'b0;
    chk("rw_pend", 48'(pending), 48'h1);
    chk("rw_hold", 48'(tgt_of(0)), 48'd100);
    step();
    angle_done = 4'b0001;
    step();
    angle_done = 4'd0;
    chk("rw_hold2", 48'(tgt_of(0)), 48'd100);
    wait_update(0, 200, "rw2");
    finish_move(0);

    // Asynchronous reset during a move.
    put(1, 5);
    step();
    put(2, 7);
    step();
    wr_en = 1'b0;
    chk("ar_upd", 48'(angle_update), 48'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_upd0", 48'(angle_update), 48'd0);
    chk("ar_pend0", 48'(pending), 48'd0);
    chk("ar_busy0", 48'(busy), 48'd0);
    step();
    reset = 1'b0;
    put(3, 9);
    step();
    put(0, 11);
    step();
    wr_en = 1'b0;
    wait_update(3, 9, "ar3");
    finish_move(3);
    wait_update(0, 11, "ar0");
    finish_move(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
